// File: rtl/dmni_br_svc_rx_pkg.sv
// DMNI shared types for the BrLite service receive path.
// Holds the service message layout, the MMR map and the FIFO default depth.
package DMNIPkg;

  localparam int BRLITE_SVC_BUFFER_SIZE = 8;

  typedef struct packed {
    logic [31:0] payload;
    logic [15:0] seq_source;
    logic [15:0] producer;
    logic [7:0]  ksvc;
  } brlite_svc_t;

  typedef enum logic [4:0] {
    DMNI_STATUS          = 5'h00,
    DMNI_BR_START        = 5'h10,
    DMNI_BR_SVC_KSVC     = 5'h11,
    DMNI_BR_SVC_PRODUCER = 5'h12,
    DMNI_BR_SVC_PAYLOAD  = 5'h13,
    DMNI_BR_SVC_POP      = 5'h14,
    DMNI_PENDING_SVC     = 5'h15,
    DMNI_BR_MON_CLEAR    = 5'h16
  } dmni_mmr_t;

endpackage

// File: rtl/brlite_svc_fifo.sv
// Synchronous FIFO of BrLite service messages.
// Head entry is exposed combinationally; push when full / pop when empty are ignored.
module brlite_svc_fifo
  import DMNIPkg::*;
#(
  parameter int DEPTH = BRLITE_SVC_BUFFER_SIZE,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  brlite_svc_t   din,
  output brlite_svc_t   head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  brlite_svc_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; pointers wrap on their own width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmni_br_svc_rx.sv
// BrLite service receive path: router handshake, FIFO, MMR reads and pop.
// Define DMNI_BR_SVC_DROP_EN to ack-and-drop when full with a drop counter.
module dmni_br_svc_rx
  import DMNIPkg::*;
#(
  parameter int BUFFER_SIZE = BRLITE_SVC_BUFFER_SIZE
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_i,
  output logic                         ack_o,
  input  brlite_svc_t                  data_i,
  input  logic                         cfg_en_i,
  input  logic                         cfg_we_i,
  input  dmni_mmr_t                    cfg_addr_i,
  input  logic [31:0]                  cfg_data_i,
  output logic [31:0]                  cfg_data_o,
`ifdef DMNI_BR_SVC_DROP_EN
  output logic                         drop_o,
`endif
  output logic                         pending_o,
  output logic [$clog2(BUFFER_SIZE):0] count_o
);

  brlite_svc_t head;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        rd;
  logic [31:0] rd_val;
  logic        unused;

  assign pop = cfg_en_i && cfg_we_i && (cfg_addr_i == DMNI_BR_SVC_POP);
  assign rd  = cfg_en_i && !cfg_we_i;

  // POP writes carry no data; seq_source is not exposed through MMRs.
  assign unused = ^{cfg_data_i, head.seq_source};

`ifdef DMNI_BR_SVC_DROP_EN
  logic        drop;
  logic        clr;
  logic [15:0] drop_cnt;

  assign ack_o = req_i;
  assign push  = req_i && !full;
  assign drop  = req_i && full;
  assign clr   = cfg_en_i && cfg_we_i && (cfg_addr_i == DMNI_BR_MON_CLEAR);

  // Saturating drop monitor; a clear write wins over a same-cycle drop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drop_cnt <= '0;
      drop_o   <= 1'b0;
    end else begin
      drop_o <= drop;
      if (clr)
        drop_cnt <= '0;
      else if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign ack_o = req_i && !full;
  assign push  = ack_o;
`endif

  brlite_svc_fifo #(
    .DEPTH (BUFFER_SIZE)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .din   (data_i),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count_o)
  );

  assign pending_o = !empty;

  // MMR read mux; head fields read as zero while the FIFO is empty.
  always_comb begin
    rd_val = '0;
    case (cfg_addr_i)
      DMNI_BR_SVC_KSVC:
        if (!empty) rd_val = {24'd0, head.ksvc};
      DMNI_BR_SVC_PRODUCER:
        if (!empty) rd_val = {16'd0, head.producer};
      DMNI_BR_SVC_PAYLOAD:
        if (!empty) rd_val = head.payload;
      DMNI_PENDING_SVC:
        rd_val = 32'(count_o);
`ifdef DMNI_BR_SVC_DROP_EN
      DMNI_BR_MON_CLEAR:
        rd_val = {16'd0, drop_cnt};
`endif
      default:
        rd_val = '0;
    endcase
  end

  // Registered read data, held between read strobes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cfg_data_o <= '0;
    else if (rd)
      cfg_data_o <= rd_val;
  end

endmodule
